// File: rtl/chunked_adder.sv
// Multi-cycle WIDTH-bit adder: CHUNK bits per clock, LSB chunk first, registered carry chain.
// Define SUB_EN to add the sub port (a - b via inverted B and forced carry-in).
module chunked_adder #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned NCHUNK   = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
    localparam int unsigned IDX_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned SAFE_DIV = (CHUNK == 0) ? 1 : CHUNK;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    // Reject configurations where the operand does not split into whole chunks
    generate
        if ((CHUNK == 0) || ((WIDTH % SAFE_DIV) != 0)) begin : g_cfg_err
            $error("chunked_adder: WIDTH must be a nonzero multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_d;
    logic             accept_c, last_c, sub_c;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] op_a, op_b;
    int unsigned      shift_c;
    logic [CHUNK-1:0] a_chunk_c, b_chunk_c;
    logic [CHUNK:0]   chunk_sum_c;

`ifdef SUB_EN
    assign sub_c = sub;
`else
    assign sub_c = 1'b0;
`endif

    // State register plus registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            busy  <= (state_d == S_RUN);
            done  <= (state_d == S_DONE);
        end
    end

    // Next-state logic; start is only honoured outside RUN
    always_comb begin
        state_d  = state;
        accept_c = 1'b0;
        last_c   = (idx == LAST_IDX);
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept_c = 1'b1;
                    state_d  = S_RUN;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_c) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Current chunk slice and its add
    assign shift_c     = 32'(idx) * CHUNK;
    assign a_chunk_c   = CHUNK'(op_a >> shift_c);
    assign b_chunk_c   = CHUNK'(op_b >> shift_c);
    assign chunk_sum_c = {1'b0, a_chunk_c} + {1'b0, b_chunk_c} + (CHUNK + 1)'(carry);

    // Operand latch and chunk-serial datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept_c) begin
            op_a  <= a;
            op_b  <= sub_c ? ~b : b;
            carry <= sub_c | cin;
            idx   <= '0;
        end else if (state == S_RUN) begin
            sum   <= (sum & ~(CHUNK_MASK << shift_c))
                   | (WIDTH'(chunk_sum_c[CHUNK-1:0]) << shift_c);
            carry <= chunk_sum_c[CHUNK];
            if (last_c) begin
                cout <= chunk_sum_c[CHUNK];
            end else begin
                idx  <= idx + IDX_W'(1);
            end
        end
    end

endmodule
